// File: rtl/membus_arbiter.sv
// Two-master (instruction fetch / data) to one-slave memory bus arbiter with an in-order tag FIFO.
// Define MEMBUS_ARB_RR_EN for round-robin grant; otherwise the data master has fixed priority.
module membus_arbiter #(
  parameter int XLEN            = 64,
  parameter int ILEN            = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction-fetch master (read-only)
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [XLEN-1:0]         i_addr,
  output logic                    i_rvalid,
  output logic [ILEN-1:0]         i_rdata,
  // data master
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [XLEN-1:0]         d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // downstream slave
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [XLEN-1:0]         m_addr,
  output logic                    m_wen,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic src;   // 1 = fetch, 0 = data
    logic half;  // fetch address bit 2: selects the upper 32-bit half of the response
  } tag_t;

  tag_t             r_tags [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_space;
  logic w_grant_d;
  logic w_grant_i;
  tag_t w_head;
  tag_t w_push_tag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_pop   = m_rvalid & ~w_empty;
  // A response retiring this cycle frees its slot for a same-cycle request.
  assign w_space = ~w_full | w_pop;
  assign w_head  = r_tags[r_rd_ptr];

  // ---------------------------------------------------------------- grant
`ifdef MEMBUS_ARB_RR_EN
  logic r_rr_last;  // 1 = fetch was granted last

  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (d_valid && i_valid) begin
      w_grant_d = r_rr_last;
      w_grant_i = ~r_rr_last;
    end else begin
      w_grant_d = d_valid;
      w_grant_i = i_valid;
    end
  end

  assign d_ready = ~rst & m_ready & w_space & ~w_grant_i;
  assign i_ready = ~rst & m_ready & w_space & ~w_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last <= 1'b0;
    end else if (w_push) begin
      r_rr_last <= w_grant_i;
    end
  end
`else
  assign w_grant_d = d_valid;
  assign w_grant_i = i_valid & ~d_valid;
  assign d_ready   = ~rst & m_ready & w_space;
  assign i_ready   = ~rst & m_ready & w_space & ~d_valid;
`endif

  // ---------------------------------------------------------- request path
  assign m_valid = ~rst & (i_valid | d_valid) & w_space;
  assign w_push  = m_valid & m_ready;

  assign m_addr  = w_grant_d ? d_addr  : i_addr;
  assign m_wen   = w_grant_d & d_wen;
  assign m_wdata = w_grant_d ? d_wdata : '0;
  assign m_wmask = w_grant_d ? d_wmask : '0;

  assign w_push_tag.src  = ~w_grant_d;
  assign w_push_tag.half = ~w_grant_d & i_addr[2];

  // --------------------------------------------------------- response path
  assign i_rvalid = ~rst & w_pop & w_head.src;
  assign d_rvalid = ~rst & w_pop & ~w_head.src;
  assign i_rdata  = w_head.half ? m_rdata[DATA_WIDTH-1:ILEN] : m_rdata[ILEN-1:0];
  assign d_rdata  = m_rdata;

  // ------------------------------------------------------------- tag FIFO
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: tag storage has no reset; an entry is only read after a push has
  // written it, and the reset pointers/count make stale contents invisible.
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= w_push_tag;
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter (default build; extra grant checks when MEMBUS_ARB_RR_EN is defined).
`timescale 1ns/1ps
module tb_membus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_rvalid;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_valid, d_ready, d_wen, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        m_valid, m_ready, m_wen, m_rvalid;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wmask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  membus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_valid = 0; i_addr = '0;
    d_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0; d_wmask = '0;
    m_ready = 1; m_rvalid = 0; m_rdata = '0;
  endtask

  initial begin
    // reset with every input active: gated outputs must be 0
    idle();
    rst = 1; i_valid = 1; d_valid = 1; m_rvalid = 1;
    #1;
    check("rst_m_valid",  m_valid,  0);
    check("rst_i_ready",  i_ready,  0);
    check("rst_d_ready",  d_ready,  0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    @(negedge clk); idle(); rst = 0;

    // fetch only, upper half
    @(negedge clk);
    i_valid = 1; i_addr = 64'h1004; #1;
    check("f_i_ready", i_ready, 1);
    check("f_m_valid", m_valid, 1);
    check("f_m_addr",  m_addr,  64'h1004);
    check("f_m_wen",   m_wen,   0);
`ifndef MEMBUS_ARB_RR_EN
    check("f_d_ready_fixed", d_ready, 1);
`endif
    @(negedge clk);
    i_valid = 0; m_rvalid = 1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    check("f_i_rvalid", i_rvalid, 1);
    check("f_i_rdata",  i_rdata,  32'hAAAABBBB);
    check("f_d_rvalid", d_rvalid, 0);

    // simultaneous valids: data wins, then fetch; responses in order
    @(negedge clk);
    m_rvalid = 0;
    i_valid = 1; i_addr = 64'h3000;
    d_valid = 1; d_addr = 64'h2000; d_wen = 1; d_wdata = 64'h1122_3344_5566_7788; d_wmask = 8'hFF; #1;
    check("s_m_addr",  m_addr,  64'h2000);
    check("s_m_wen",   m_wen,   1);
    check("s_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
    check("s_m_wmask", m_wmask, 8'hFF);
    check("s_i_ready", i_ready, 0);
    check("s_d_ready", d_ready, 1);
    @(negedge clk);
    d_valid = 0; d_wen = 0; #1;
    check("s2_m_addr",  m_addr,  64'h3000);
    check("s2_i_ready", i_ready, 1);
    check("s2_m_wen",   m_wen,   0);
    check("s2_m_wmask", m_wmask, 8'h00);
    check("s2_m_wdata", m_wdata, 64'h0);
    @(negedge clk);
    i_valid = 0; m_rvalid = 1; m_rdata = 64'h0102_0304_0506_0708; #1;
    check("s_rsp1_d_rvalid", d_rvalid, 1);
    check("s_rsp1_i_rvalid", i_rvalid, 0);
    check("s_rsp1_d_rdata",  d_rdata,  64'h0102_0304_0506_0708);
    @(negedge clk);
    m_rdata = 64'h5555_6666_7777_8888; #1;
    check("s_rsp2_i_rvalid", i_rvalid, 1);
    check("s_rsp2_d_rvalid", d_rvalid, 0);
    check("s_rsp2_i_rdata",  i_rdata,  32'h77778888);

    // FIFO full with two fetch reads outstanding
    @(negedge clk);
    m_rvalid = 0; i_valid = 1; i_addr = 64'h10;
    @(negedge clk);
    i_addr = 64'h14;
    @(negedge clk);
    d_valid = 1; #1;
    check("full_m_valid", m_valid, 0);
    check("full_i_ready", i_ready, 0);
    check("full_d_ready", d_ready, 0);
    #1;
    d_valid = 0; i_addr = 64'h18; m_rvalid = 1; m_rdata = 64'hDEAD_BEEF_0123_4567; #1;
    check("full_pop_m_valid",  m_valid,  1);
    check("full_pop_i_ready",  i_ready,  1);
    check("full_pop_i_rvalid", i_rvalid, 1);
    check("full_pop_i_rdata",  i_rdata,  32'h01234567);
    @(negedge clk);
    m_rvalid = 0; #1;
    check("full_still_m_valid", m_valid, 0);
    i_valid = 0; m_rvalid = 1; m_rdata = 64'h8888_9999_AAAA_BBBB; #1;
    check("drain1_i_rdata", i_rdata, 32'h88889999);
    @(negedge clk);
    m_rdata = 64'h1111_2222_3333_4444; #1;
    check("drain2_i_rvalid", i_rvalid, 1);
    check("drain2_i_rdata",  i_rdata,  32'h33334444);

    // stray response on empty FIFO
    @(negedge clk); #1;
    check("stray_i_rvalid", i_rvalid, 0);
    check("stray_d_rvalid", d_rvalid, 0);

    // async reset with two data reads outstanding
    @(negedge clk);
    m_rvalid = 0; d_valid = 1; d_wen = 0; d_addr = 64'h40;
    @(negedge clk);
    d_addr = 64'h48;
    @(negedge clk);
    d_valid = 0; i_valid = 1; m_rvalid = 1; m_rdata = 64'hCAFE; #1;
    check("prerst_d_rvalid", d_rvalid, 1);
    rst = 1; #1;
    check("midrst_d_rvalid", d_rvalid, 0);
    check("midrst_i_rvalid", i_rvalid, 0);
    check("midrst_m_valid",  m_valid,  0);
    check("midrst_i_ready",  i_ready,  0);
    check("midrst_d_ready",  d_ready,  0);
    i_valid = 0; rst = 0; #1;
    check("postrst_d_rvalid", d_rvalid, 0);
    @(negedge clk); #1;
    check("late_d_rvalid", d_rvalid, 0);
    check("late_i_rvalid", i_rvalid, 0);
    m_rvalid = 0; i_valid = 1; #1;
    check("postrst_i_ready", i_ready, 1);
    i_valid = 0;

`ifdef MEMBUS_ARB_RR_EN
    // one fetch handshake first, then four contended handshakes alternate data/fetch
    @(negedge clk);
    rst = 1; #1; rst = 0;
    @(negedge clk);
    i_valid = 1; i_addr = 64'h100; #1;
    check("rr_pre_i_ready", i_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_valid = 1; i_addr = 64'h200;
      d_valid = 1; d_addr = 64'h900;
      m_rvalid = 1; m_rdata = 64'h0; #1;
      check("rr_m_addr",   m_addr,   (k % 2 == 0) ? 64'h900 : 64'h200);
      check("rr_d_ready",  d_ready,  (k % 2 == 0));
      check("rr_i_ready",  i_ready,  (k % 2 == 1));
      check("rr_d_rvalid", d_rvalid, (k % 2 == 1));
    end
    @(negedge clk);
    i_valid = 0; d_valid = 0; #1;
    check("rr_last_i_rvalid", i_rvalid, 1);
    @(negedge clk);
    m_rvalid = 0;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
